// File: rtl/hazard_pkg.sv
// Shared opcode constants, forwarding encodings, shadow-pipe entry type and
// opcode classification helpers for the decode hazard scoreboard.
package hazard_pkg;

   localparam int unsigned PKG_OP_W = 6;
   localparam int unsigned ENTRY_AW = 8;

   localparam logic [PKG_OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [PKG_OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [PKG_OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [PKG_OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [1:0] FWD_REGFILE = 2'd0;
   localparam logic [1:0] FWD_EXMEM   = 2'd1;
   localparam logic [1:0] FWD_MEMWB   = 2'd2;

   // One in-flight destination; dest is wide enough for any supported REG_AW
   typedef struct packed {
      logic                v;
      logic                is_load;
      logic [ENTRY_AW-1:0] dest;
   } hz_entry_t;

   function automatic logic op_writes(input logic [PKG_OP_W-1:0] op);
      return (op == OP_ADDI) || (op == OP_LW) || (op == OP_RTYPE);
   endfunction

   function automatic logic op_is_load(input logic [PKG_OP_W-1:0] op);
      return op == OP_LW;
   endfunction

   function automatic logic op_reads_rs(input logic [PKG_OP_W-1:0] op);
      return op != OP_J;
   endfunction

   function automatic logic op_reads_rt(input logic [PKG_OP_W-1:0] op);
      return op == OP_RTYPE;
   endfunction

endpackage

// File: rtl/hazard_match_unit.sv
// Compares one decode source index against every shadow-pipe entry and
// picks the bypass select from the youngest matching producer.
module hazard_match_unit
   import hazard_pkg::*;
#(
   parameter int unsigned DEPTH = 3
) (
   input  logic [ENTRY_AW-1:0]   src,
   input  logic                  src_rd,
   input  hz_entry_t [DEPTH-1:0] ent,
   output logic [DEPTH-1:0]      match_c,
   output logic [1:0]            fwd_sel_c
);

   logic unused_ent;
   assign unused_ent = ^ent;

   always_comb begin
      match_c   = '0;
      fwd_sel_c = FWD_REGFILE;
      for (int k = 0; k < int'(DEPTH); k++) begin
         match_c[k] = ent[k].v && (ent[k].dest != '0) && (ent[k].dest == src) && src_rd;
      end
      // A load still in EX cannot be bypassed; the stall covers it
      if (match_c[0]) begin
         fwd_sel_c = ent[0].is_load ? FWD_REGFILE : FWD_EXMEM;
      end else if (match_c[1]) begin
         fwd_sel_c = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard with a DEPTH-entry shadow pipe of destinations.
// Define HAZARD_SCOREBOARD_FWD_EN for load-use-only stalls and live bypass selects.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned OP_W   = 6,
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dec_valid,
   input  logic [OP_W-1:0]   dec_opcode,
   input  logic [REG_AW-1:0] dec_rs,
   input  logic [REG_AW-1:0] dec_rt,
   input  logic [REG_AW-1:0] dec_dest,
   input  logic              pipe_hold,
   input  logic              flush,
   output logic              stall,
   output logic [1:0]        fwd_rs_sel,
   output logic [1:0]        fwd_rt_sel,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   hz_entry_t [DEPTH-1:0] pipe_q, pipe_d;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

   logic [PKG_OP_W-1:0] op_c;
   logic [ENTRY_AW-1:0] rs_c, rt_c, dest_c;
   logic                rs_rd_c, rt_rd_c;
   logic [DEPTH-1:0]    rs_match_c, rt_match_c;
   logic [1:0]          rs_sel_c, rt_sel_c;
   logic                any_match_c, load_use_c, hazard_c, stall_c;
   logic                unused_cfg;

   // Decode classification
   always_comb begin
      op_c    = PKG_OP_W'(dec_opcode);
      rs_c    = ENTRY_AW'(dec_rs);
      rt_c    = ENTRY_AW'(dec_rt);
      dest_c  = ENTRY_AW'(dec_dest);
      rs_rd_c = op_reads_rs(op_c);
      rt_rd_c = op_reads_rt(op_c);
   end

   hazard_match_unit #(.DEPTH(DEPTH)) u_match_rs (
      .src       (rs_c),
      .src_rd    (rs_rd_c),
      .ent       (pipe_q),
      .match_c   (rs_match_c),
      .fwd_sel_c (rs_sel_c)
   );

   hazard_match_unit #(.DEPTH(DEPTH)) u_match_rt (
      .src       (rt_c),
      .src_rd    (rt_rd_c),
      .ent       (pipe_q),
      .match_c   (rt_match_c),
      .fwd_sel_c (rt_sel_c)
   );

   always_comb begin
      any_match_c = |{rs_match_c, rt_match_c};
      load_use_c  = (rs_match_c[0] | rt_match_c[0]) & pipe_q[0].is_load;
`ifdef HAZARD_SCOREBOARD_FWD_EN
      hazard_c    = load_use_c;
`else
      hazard_c    = any_match_c;
`endif
      stall_c     = dec_valid && !flush && hazard_c;
   end

`ifdef HAZARD_SCOREBOARD_FWD_EN
   // A stalled instruction does not execute, so its selects are parked at regfile
   assign fwd_rs_sel = stall_c ? FWD_REGFILE : rs_sel_c;
   assign fwd_rt_sel = stall_c ? FWD_REGFILE : rt_sel_c;
   assign unused_cfg = any_match_c;
`else
   assign fwd_rs_sel = FWD_REGFILE;
   assign fwd_rt_sel = FWD_REGFILE;
   assign unused_cfg = ^{load_use_c, rs_sel_c, rt_sel_c};
`endif

   // Shadow pipe advance and saturating stall counter
   always_comb begin
      pipe_d      = pipe_q;
      stall_cnt_d = stall_cnt_q;
      if (stall_c && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush) begin
         pipe_d = '0;
      end else if (!pipe_hold) begin
         for (int k = int'(DEPTH) - 1; k > 0; k--) begin
            pipe_d[k] = pipe_q[k-1];
         end
         pipe_d[0].v       = dec_valid && op_writes(op_c) && !stall_c && (dest_c != '0);
         pipe_d[0].is_load = op_is_load(op_c);
         pipe_d[0].dest    = dest_c;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         pipe_q      <= pipe_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall     = stall_c;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// stimulus against an age-based model of in-flight producers.
module tb_hazard_scoreboard;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned OP_W   = 6;
   localparam int unsigned DEPTH  = 3;
   localparam int unsigned CNT_W  = 16;

   localparam logic [5:0] T_RTYPE = 6'b000000;
   localparam logic [5:0] T_ADDI  = 6'b001000;
   localparam logic [5:0] T_LW    = 6'b100011;
   localparam logic [5:0] T_J     = 6'b000010;
   localparam logic [5:0] T_SW    = 6'b101011;

`ifdef HAZARD_SCOREBOARD_FWD_EN
   localparam bit         FWD        = 1'b1;
   localparam logic [3:0] RAW_STALL  = 4'b0000;
   localparam logic [7:0] RAW_RS_SEL = {2'd0, 2'd0, 2'd2, 2'd1};
   localparam int         RAW_CNT    = 0;
   localparam logic [2:0] GAP_STALL  = 3'b000;
   localparam logic [5:0] GAP_RS_SEL = {2'd0, 2'd0, 2'd2};
   localparam logic [3:0] LU_STALL   = 4'b0001;
   localparam logic [7:0] LU_RT_SEL  = {2'd0, 2'd0, 2'd2, 2'd0};
   localparam int         LU_CNT     = 1;
`else
   localparam bit         FWD        = 1'b0;
   localparam logic [3:0] RAW_STALL  = 4'b0111;
   localparam logic [7:0] RAW_RS_SEL = 8'd0;
   localparam int         RAW_CNT    = 3;
   localparam logic [2:0] GAP_STALL  = 3'b011;
   localparam logic [5:0] GAP_RS_SEL = 6'd0;
   localparam logic [3:0] LU_STALL   = 4'b0111;
   localparam logic [7:0] LU_RT_SEL  = 8'd0;
   localparam int         LU_CNT     = 3;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              dec_valid;
   logic [OP_W-1:0]   dec_opcode;
   logic [REG_AW-1:0] dec_rs, dec_rt, dec_dest;
   logic              pipe_hold, flush;
   logic              stall;
   logic [1:0]        fwd_rs_sel, fwd_rt_sel;
   logic [CNT_W-1:0]  stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .REG_AW(REG_AW), .OP_W(OP_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .dec_valid  (dec_valid),
      .dec_opcode (dec_opcode),
      .dec_rs     (dec_rs),
      .dec_rt     (dec_rt),
      .dec_dest   (dec_dest),
      .pipe_hold  (pipe_hold),
      .flush      (flush),
      .stall      (stall),
      .fwd_rs_sel (fwd_rs_sel),
      .fwd_rt_sel (fwd_rt_sel),
      .stall_cnt  (stall_cnt)
   );

   // Model: each issued writer lives for DEPTH advancing edges, tagged by age
   typedef struct {
      logic [4:0] dest;
      bit         load;
      int         age;
   } prod_t;

   prod_t inflight[$];
   int    exp_cnt = 0;

   function automatic void youngest(input logic [4:0] src, input bit rd,
                                    output int age, output bit ld);
      age = -1;
      ld  = 1'b0;
      if (rd && src != 5'd0) begin
         foreach (inflight[i]) begin
            if (inflight[i].dest == src && (age < 0 || inflight[i].age < age)) begin
               age = inflight[i].age;
               ld  = inflight[i].load;
            end
         end
      end
   endfunction

   function automatic logic [1:0] sel_of(input int age, input bit ld);
      if (age == 0) return ld ? 2'd0 : 2'd1;
      if (age == 1) return 2'd2;
      return 2'd0;
   endfunction

   function automatic void model_expect(output bit s, output logic [1:0] rs_s,
                                        output logic [1:0] rt_s);
      int a_rs, a_rt;
      bit l_rs, l_rt, haz;
      youngest(dec_rs, dec_opcode != T_J, a_rs, l_rs);
      youngest(dec_rt, dec_opcode == T_RTYPE, a_rt, l_rt);
      if (FWD) haz = (a_rs == 0 && l_rs) || (a_rt == 0 && l_rt);
      else     haz = (a_rs >= 0) || (a_rt >= 0);
      s    = dec_valid && !flush && haz;
      rs_s = (FWD && !s) ? sel_of(a_rs, l_rs) : 2'd0;
      rt_s = (FWD && !s) ? sel_of(a_rt, l_rt) : 2'd0;
   endfunction

   task automatic model_reset();
      inflight.delete();
      exp_cnt = 0;
   endtask

   task automatic step_model();
      bit s;
      logic [1:0] a, b;
      bit wr;
      model_expect(s, a, b);
      if (s && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
      wr = (dec_opcode == T_RTYPE) || (dec_opcode == T_ADDI) || (dec_opcode == T_LW);
      if (flush) begin
         inflight.delete();
      end else if (!pipe_hold) begin
         foreach (inflight[i]) inflight[i].age++;
         for (int i = inflight.size() - 1; i >= 0; i--)
            if (inflight[i].age >= int'(DEPTH)) inflight.delete(i);
         if (dec_valid && wr && !s && dec_dest != 5'd0)
            inflight.push_back('{dest: dec_dest, load: (dec_opcode == T_LW), age: 0});
      end
   endtask

   task automatic drive(input bit v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] d,
                        input bit h, input bit f);
      dec_valid  = v;
      dec_opcode = op;
      dec_rs     = rs;
      dec_rt     = rt;
      dec_dest   = d;
      pipe_hold  = h;
      flush      = f;
      #1;
   endtask

   task automatic tick();
      step_model();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         drive(1'b0, T_RTYPE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1'b0, T_RTYPE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checks++;
      if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0 || stall_cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_outputs: stall=%b rs=%0d rt=%0d cnt=%0d, want 0/0/0/0",
                  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      drive(1'b1, T_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
      checks++;
      if (stall !== 1'b0 || stall_cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_release: stall=%b cnt=%0d, want 0/0", stall, stall_cnt);
      end
      tick();
   endtask

   task automatic test_raw_alu();
      int base;
      idle(DEPTH);
      base = exp_cnt;
      drive(1'b1, T_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, T_RTYPE, 5'd3, 5'd0, 5'd6, 1'b0, 1'b0);
         checks++;
         if (stall !== RAW_STALL[c] || fwd_rs_sel !== RAW_RS_SEL[2*c +: 2]) begin
            failures++;
            $display("FAIL raw_alu_c%0d: stall=%b rs_sel=%0d, want %b/%0d",
                     c, stall, fwd_rs_sel, RAW_STALL[c], RAW_RS_SEL[2*c +: 2]);
         end
         tick();
      end
      checks++;
      if (stall_cnt !== 16'(base + RAW_CNT)) begin
         failures++;
         $display("FAIL raw_alu_cnt: got %0d want %0d", stall_cnt, base + RAW_CNT);
      end
   endtask

   task automatic test_raw_gap();
      idle(DEPTH);
      drive(1'b1, T_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
      tick();
      drive(1'b1, T_ADDI, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, T_RTYPE, 5'd3, 5'd0, 5'd6, 1'b0, 1'b0);
         checks++;
         if (stall !== GAP_STALL[c] || fwd_rs_sel !== GAP_RS_SEL[2*c +: 2]) begin
            failures++;
            $display("FAIL raw_gap_c%0d: stall=%b rs_sel=%0d, want %b/%0d",
                     c, stall, fwd_rs_sel, GAP_STALL[c], GAP_RS_SEL[2*c +: 2]);
         end
         tick();
      end
   endtask

   task automatic test_load_use();
      int base;
      idle(DEPTH);
      base = exp_cnt;
      drive(1'b1, T_LW, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, T_RTYPE, 5'd2, 5'd5, 5'd8, 1'b0, 1'b0);
         checks++;
         if (stall !== LU_STALL[c] || fwd_rt_sel !== LU_RT_SEL[2*c +: 2]) begin
            failures++;
            $display("FAIL load_use_c%0d: stall=%b rt_sel=%0d, want %b/%0d",
                     c, stall, fwd_rt_sel, LU_STALL[c], LU_RT_SEL[2*c +: 2]);
         end
         tick();
      end
      checks++;
      if (stall_cnt !== 16'(base + LU_CNT)) begin
         failures++;
         $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, base + LU_CNT);
      end
   endtask

   task automatic test_zero_reg();
      idle(DEPTH);
      drive(1'b1, T_ADDI, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 2; c++) begin
         drive(1'b1, T_RTYPE, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
         checks++;
         if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
            failures++;
            $display("FAIL zero_reg_c%0d: stall=%b rs=%0d rt=%0d, want 0/0/0",
                     c, stall, fwd_rs_sel, fwd_rt_sel);
         end
         tick();
      end
   endtask

   task automatic test_flush();
      idle(DEPTH);
      drive(1'b1, T_RTYPE, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0);
      tick();
      drive(1'b1, T_RTYPE, 5'd4, 5'd4, 5'd10, 1'b0, 1'b1);
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL flush_cycle: stall=%b want 0", stall);
      end
      tick();
      drive(1'b1, T_RTYPE, 5'd4, 5'd4, 5'd10, 1'b0, 1'b0);
      checks++;
      if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
         failures++;
         $display("FAIL flush_after: stall=%b rs=%0d rt=%0d, want 0/0/0",
                  stall, fwd_rs_sel, fwd_rt_sel);
      end
      tick();
   endtask

   task automatic test_hold_reset();
      int base;
      idle(DEPTH);
      base = exp_cnt;
      drive(1'b1, T_LW, 5'd1, 5'd0, 5'd9, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, T_RTYPE, 5'd9, 5'd2, 5'd11, 1'b1, 1'b0);
         checks++;
         if (stall !== 1'b1) begin
            failures++;
            $display("FAIL hold_c%0d: stall=%b want 1", c, stall);
         end
         tick();
      end
      drive(1'b1, T_RTYPE, 5'd9, 5'd2, 5'd11, 1'b0, 1'b0);
      checks++;
      if (stall !== 1'b1 || stall_cnt !== 16'(base + 4)) begin
         failures++;
         $display("FAIL hold_release: stall=%b cnt=%0d, want 1/%0d", stall, stall_cnt, base + 4);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || stall_cnt !== 16'd0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
         failures++;
         $display("FAIL mid_reset: stall=%b cnt=%0d rs=%0d rt=%0d, want 0/0/0/0",
                  stall, stall_cnt, fwd_rs_sel, fwd_rt_sel);
      end
      model_reset();
      dec_valid = 1'b0;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_random();
      logic [5:0] ops [5] = '{T_RTYPE, T_ADDI, T_LW, T_J, T_SW};
      bit es;
      logic [1:0] ers, ert;
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 99) < 85, ops[$urandom_range(0, 4)],
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5);
         model_expect(es, ers, ert);
         checks++;
         if (stall !== es || fwd_rs_sel !== ers || fwd_rt_sel !== ert || stall_cnt !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL random_n%0d: stall=%b rs=%0d rt=%0d cnt=%0d, want %b/%0d/%0d/%0d",
                     n, stall, fwd_rs_sel, fwd_rt_sel, stall_cnt, es, ers, ert, exp_cnt);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_raw_alu();
      test_raw_gap();
      test_load_use();
      test_zero_reg();
      test_flush();
      test_hold_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard detector, sitting beside the decode stage of the 5-stage MIPS-subset core.
- Keeps its own shadow pipeline of in-flight destination registers, DEPTH entries deep.
- Raises a decode stall when a source register is still in flight.
- When forwarding is compiled in, stalls only on load-use and drives bypass-mux selects.
- Also tracks flushes, back-end holds and a saturating stall counter.

Parameters:
- REG_AW, 5, register-index width (2**REG_AW architectural regs; reg 0 never hazards)
- OP_W, 6, opcode width
- DEPTH, 3, shadow pipe entries (EX, MEM, WB), min 2
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- dec_valid  in  1  decode stage holds a real instruction
- dec_opcode  in  OP_W  opcode in decode
- dec_rs  in  REG_AW  source A index
- dec_rt  in  REG_AW  source B index
- dec_dest  in  REG_AW  resolved destination (rt/rd mux output)
- pipe_hold  in  1  back end frozen; shadow pipe must not advance
- flush  in  1  branch/jump redirect; kill all in-flight entries
- stall  out  1  hold PC/IF-ID, inject bubble into EX
- fwd_rs_sel  out  2  0 regfile, 1 from EX/MEM, 2 from MEM/WB
- fwd_rt_sel  out  2  same encoding for rt
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Decode classification:
  - writes = addi 001000, lw 100011, R-type 000000
  - is_load = lw
  - reads rs: every opcode except j 000010
  - reads rt: R-type only
  - reads nothing for j
- Shadow pipe entry = {v, is_load, dest}; entry 0 = EX, entry k = stage EX+k.
- Match on entry k: v && dest != 0 && dest == source && source is read by the decoded instruction.
- stall is combinational, the same cycle as the inputs: dec_valid && !flush && hazard.
  - Without forwarding, hazard = match on any entry 0..DEPTH-1.
  - With forwarding, hazard = match on entry 0 with is_load.
- Shift on each clk edge, unless pipe_hold = 1:
  - entry k+1 <= entry k
  - entry 0 <= {dec_valid && writes && !stall, is_load, dec_dest}
  - A stalled cycle therefore enters a bubble (v = 0).
- pipe_hold = 1: all entries hold; stall is still evaluated against the held contents.
- flush = 1 (priority over hold and shift): all v <= 0 next edge; stall forced 0 that cycle.
- Writes to reg 0 never allocate a valid entry.
- fwd_*_sel:
  - Forwarding configuration: 1 if entry 0 matches and is not a load; else 2 if entry 1 matches; else 0. The youngest match wins.
  - A load match in entry 0 produces stall, and fwd_*_sel = 0 that cycle.
  - Non-forwarding configuration: fwd_*_sel held at 0.
- stall_cnt increments on every clk edge where stall = 1, and saturates at all-ones.
- Reset (rst = 0, asynchronous): all v = 0, stall_cnt = 0.
  - Outputs then read stall = 0 and fwd sels = 0 combinationally.
  - Reset mid-operation drops all in-flight hazards; the core is also reset.
- Latency:
  - Without forwarding, a dependent instruction stalls DEPTH cycles behind its producer (3 by default).
  - With forwarding: 0 stall cycles for ALU producers, 1 for loads.

Optional Feature:
- Macro HAZARD_SCOREBOARD_FWD_EN.
- Defined: forwarding hazard rule and live fwd_rs_sel/fwd_rt_sel.
- Undefined: full-window stall rule; fwd selects tied to 0.
- Ports are identical in both builds.

Decomposition:
- Package hazard_pkg:
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_J
  - FWD_REGFILE/FWD_EXMEM/FWD_MEMWB 2-bit encodings
  - entry struct typedef
  - functions op_writes, op_reads_rs, op_reads_rt
- One sub-module hazard_match_unit: compares one source index against all entries and returns the match vector plus the fwd select. It is instantiated twice (rs, rt).

Test Plan:
- add $3 issued, next cycle add reading $3 (no FWD) → stall=1 for 3 cycles, then 0; stall_cnt = 3.
- Same sequence with FWD_EN → stall = 0, fwd_rs_sel = 1 on the cycle after the producer, and 2 when one instruction intervenes.
- lw $5 followed by add reading rt=$5 with FWD_EN → exactly 1 stall cycle, then fwd_rt_sel = 2.
- addi $0 followed by a reader of $0 → stall = 0 and fwd sels = 0 in both builds.
- add $4 in flight, flush = 1 with a reader of $4 in decode → stall = 0 that cycle; next cycle, same reader → stall = 0 (entries cleared).
- pipe_hold = 1 for 4 cycles with a dependent instruction in decode (no FWD) → stall stays 1 and entries do not advance; stall_cnt +4. Also assert rst mid-stall → stall = 0 and stall_cnt = 0 immediately.
